meter_counter: RTL and testbench

METER_COUNTER -- requirements
Module: meter_counter

---
 rtl/meter_counter.sv | 130 +++++++++++++
 tb/tb_meter_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/meter_counter.sv
// rtl/meter_counter.sv - parking-meter style seconds counter with edge-detected adds,
// presets, 1 Hz countdown and a sequential double-dabble BCD converter.
module meter_counter #(
  parameter int MAX_COUNT   = 9999,
  parameter int BLINK_LIMIT = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       btnu,
  input  logic       btnl,
  input  logic       btnd,
  input  logic       btns,
  input  logic [7:0] sw,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       state_blink,
  output logic       expired
);

  localparam logic [14:0] MAX15   = 15'(MAX_COUNT);
  localparam logic [13:0] BLINK14 = 14'(BLINK_LIMIT);

  typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_DONE} conv_state_t;

  logic [13:0] count;
  logic [13:0] next_count;
  logic        clk_1hz_q;
  logic [3:0]  btn;
  logic [3:0]  btn_q;
  logic [3:0]  btn_rise;
  logic        tick;
  logic [14:0] add_sum;
  logic [14:0] sum;
  logic        unused_sw;

  conv_state_t conv_state;
  logic [13:0] bin_sr;
  logic [13:0] last_conv;
  logic [15:0] bcd;
  logic [3:0]  iter;
  logic [29:0] dd_shift;

  assign btn       = {btns, btnd, btnl, btnu};
  assign unused_sw = ^sw[7:2];

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturate before the tick so a tick at the ceiling still counts down.
  always_comb begin
    tick     = clk_1Hz & ~clk_1hz_q;
    btn_rise = btn & ~btn_q;
    add_sum  = 15'd0;
    if (btn_rise[0]) add_sum = add_sum + 15'd10;
    if (btn_rise[1]) add_sum = add_sum + 15'd180;
    if (btn_rise[2]) add_sum = add_sum + 15'd200;
    if (btn_rise[3]) add_sum = add_sum + 15'd550;
    sum = {1'b0, count} + add_sum;
    if (sum > MAX15) sum = MAX15;
    if (tick && sum != 15'd0) sum = sum - 15'd1;
    if (sw[0])      next_count = 14'd15;
    else if (sw[1]) next_count = 14'd150;
    else            next_count = 14'(sum);
    dd_shift = {add3(bcd), bin_sr} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 14'd0;
      clk_1hz_q   <= 1'b1;
      btn_q       <= 4'hf;
      state_blink <= 1'b1;
      expired     <= 1'b1;
    end else begin
      count       <= next_count;
      clk_1hz_q   <= clk_1Hz;
      btn_q       <= btn;
      state_blink <= (count < BLINK14);
      expired     <= (count == 14'd0);
    end
  end

  // Load, 14 shift-add-3 steps, then publish; a busy converter ignores count changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_state <= CONV_IDLE;
      bin_sr     <= 14'd0;
      last_conv  <= 14'd0;
      bcd        <= 16'd0;
      iter       <= 4'd0;
      digit3     <= 4'd0;
      digit2     <= 4'd0;
      digit1     <= 4'd0;
      digit0     <= 4'd0;
    end else begin
      case (conv_state)
        CONV_IDLE: begin
          if (count != last_conv) begin
            bin_sr     <= count;
            last_conv  <= count;
            bcd        <= 16'd0;
            iter       <= 4'd0;
            conv_state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          bcd    <= dd_shift[29:14];
          bin_sr <= dd_shift[13:0];
          iter   <= iter + 4'd1;
          if (iter == 4'd13) conv_state <= CONV_DONE;
        end
        CONV_DONE: begin
          {digit3, digit2, digit1, digit0} <= bcd;
          conv_state <= CONV_IDLE;
        end
        default: conv_state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meter_counter.sv
// tb/tb_meter_counter.sv - directed bench for meter_counter with an arithmetic
// reference model checked every cycle plus literal expectations.
module tb_meter_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1Hz;
  logic       btnu, btnl, btnd, btns;
  logic [7:0] sw;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       state_blink, expired;

  int vectors = 0;
  int errors  = 0;

  meter_counter dut (
    .clk(clk), .rst(rst), .clk_1Hz(clk_1Hz),
    .btnu(btnu), .btnl(btnl), .btnd(btnd), .btns(btns), .sw(sw),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .state_blink(state_blink), .expired(expired)
  );

  always #5 clk = ~clk;

  // Reference model: remaining seconds as an integer, display value as an integer.
  int   m_count, m_disp, m_conv_val, m_last, m_conv_left;
  logic m_prev1, m_blink, m_exp, started = 1'b0;
  logic [3:0] m_prevb;

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  always @(posedge clk) begin
    int s;
    logic [3:0] b, rise;
    b = {btns, btnd, btnl, btnu};
    if (rst) begin
      m_count = 0; m_disp = 0; m_conv_val = 0; m_last = 0; m_conv_left = 0;
      m_prev1 = 1'b1; m_prevb = 4'hf; m_blink = 1'b1; m_exp = 1'b1;
      started = 1'b1;
    end else begin
      m_blink = (m_count < 180);
      m_exp   = (m_count == 0);
      if (m_conv_left > 0) begin
        m_conv_left = m_conv_left - 1;
        if (m_conv_left == 0) m_disp = m_conv_val;
      end else if (m_count != m_last) begin
        m_conv_val  = m_count;
        m_last      = m_count;
        m_conv_left = 15;
      end
      rise = b & ~m_prevb;
      if (sw[0])      m_count = 15;
      else if (sw[1]) m_count = 150;
      else begin
        s = m_count + (rise[0] ? 10 : 0) + (rise[1] ? 180 : 0) +
            (rise[2] ? 200 : 0) + (rise[3] ? 550 : 0);
        if (s > 9999) s = 9999;
        if (clk_1Hz && !m_prev1 && s > 0) s = s - 1;
        m_count = s;
      end
      m_prev1 = clk_1Hz;
      m_prevb = b;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("digits", int'({digit3, digit2, digit1, digit0}), to_bcd(m_disp));
      check("state_blink", int'(state_blink), int'(m_blink));
      check("expired", int'(expired), int'(m_exp));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk) {btns, btnd, btnl, btnu} = mask;
    @(negedge clk) {btns, btnd, btnl, btnu} = 4'h0;
  endtask

  task automatic tick();
    @(negedge clk) clk_1Hz = 1'b1;
    @(negedge clk) clk_1Hz = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_1Hz = 1'b1; sw = 8'h00;
    btnu = 1'b0; btnl = 1'b0; btnd = 1'b0; btns = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    check("held_through_reset_count", m_count, 0);
    check("reset_expired", int'(expired), 1);
    check("reset_blink", int'(state_blink), 1);
    check("reset_digits", int'({digit3, digit2, digit1, digit0}), 0);
    btns = 1'b0; clk_1Hz = 1'b0;
    cyc(2);

    press(4'b1000);
    check("btns_count", m_count, 550);
    cyc(15);
    check("latency_before", int'({digit3, digit2, digit1, digit0}), 16'h0000);
    cyc(1);
    check("latency_digits_550", int'({digit3, digit2, digit1, digit0}), 16'h0550);
    check("blink_550", int'(state_blink), 0);
    check("expired_550", int'(expired), 0);

    for (int i = 0; i < 10; i++) press(4'b1111);
    for (int i = 0; i < 4; i++) press(4'b0001);
    check("count_9990", m_count, 9990);
    press(4'b0101);
    check("saturate_9999", m_count, 9999);
    cyc(20);
    check("digits_9999", int'({digit3, digit2, digit1, digit0}), 16'h9999);
    @(negedge clk) btnd = 1'b1;
    cyc(100);
    btnd = 1'b0;
    check("held_btnd", m_count, 9999);

    @(negedge clk) sw = 8'h01;
    cyc(2);
    sw = 8'h00;
    for (int i = 0; i < 14; i++) tick();
    check("count_1", m_count, 1);
    for (int i = 0; i < 3; i++) tick();
    check("no_underflow", m_count, 0);
    cyc(20);
    check("digits_zero", int'({digit3, digit2, digit1, digit0}), 0);
    check("expired_zero", int'(expired), 1);

    @(negedge clk) begin sw = 8'h02; btns = 1'b1; clk_1Hz = 1'b1; end
    @(negedge clk) begin btns = 1'b0; clk_1Hz = 1'b0; end
    check("preset_150", m_count, 150);
    @(negedge clk) sw = 8'h03;
    cyc(2);
    check("preset_15", m_count, 15);
    sw = 8'h00;

    pulse_rst();
    press(4'b0010);
    check("count_180", m_count, 180);
    cyc(20);
    check("blink_180", int'(state_blink), 0);
    tick();
    check("count_179", m_count, 179);
    cyc(1);
    check("blink_179", int'(state_blink), 1);
    press(4'b0010);
    check("count_359", m_count, 359);
    cyc(1);
    check("blink_359", int'(state_blink), 0);

    @(negedge clk) sw = 8'h01;
    cyc(1);
    sw = 8'h00;
    for (int i = 0; i < 10; i++) tick();
    check("count_5", m_count, 5);
    @(negedge clk) begin clk_1Hz = 1'b1; btnu = 1'b1; end
    @(negedge clk) begin clk_1Hz = 1'b0; btnu = 1'b0; end
    check("tick_and_add", m_count, 14);
    cyc(20);
    check("digits_14", int'({digit3, digit2, digit1, digit0}), 16'h0014);
    press(4'b0001);
    cyc(5);
    pulse_rst();
    cyc(30);
    check("abort_digits", int'({digit3, digit2, digit1, digit0}), 0);
    check("abort_count", m_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
